// File: rtl/pipe_stage_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stage_ctrl
//
// Pipeline controller for a single-clock core. It drives one clock enable and
// one valid flag per stage, instead of gating a separate clock per stage.
// Bit 0 is the fetch (youngest) stage. Bit STAGES-1 is writeback (oldest).
//
// The controller handles:
//   - a global active-low stall (stallb_en)
//   - per-stage stall requests; an older stall also holds every younger stage
//   - memory wait-state insertion through a down-counter (busy)
//   - a partial flush of the FLUSH_DEPTH youngest stages
//   - an interrupt drain that ends with a one-cycle irq_ack pulse
//
// Ports
//   clk           in   core clock; all state changes on the rising edge
//   reset         in   synchronous reset, active-low
//   stallb_en     in   global stall, active-low (0 holds every stage)
//   stg_stall_req in   per-stage stall request, bit i = stage i
//   mem_start     in   pulse that starts a memory access with wait states
//   mem_wait      in   wait-state count, sampled together with mem_start
//   flush         in   squash the valids of stages [FLUSH_DEPTH-1:0]
//   interrupt     in   level-sensitive interrupt request
//   irq_ack       out  one-cycle pulse: pipeline drained, vector may be taken
//   stg_en        out  per-stage clock enable (combinational)
//   stg_vld       out  per-stage valid (registered)
//   busy          out  wait-state counter is non-zero
// -----------------------------------------------------------------------------
module pipe_stage_ctrl #(
  parameter int STAGES      = 4,
  parameter int WAIT_WIDTH  = 4,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stallb_en,
  input  logic [STAGES-1:0]     stg_stall_req,
  input  logic                  mem_start,
  input  logic [WAIT_WIDTH-1:0] mem_wait,
  input  logic                  flush,
  input  logic                  interrupt,
  output logic                  irq_ack,
  output logic [STAGES-1:0]     stg_en,
  output logic [STAGES-1:0]     stg_vld,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam logic [WAIT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WAIT_WIDTH-1:0] CNT_ONE  = WAIT_WIDTH'(1);

  state_t                state;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic [WAIT_WIDTH-1:0] cnt_nxt;
  logic                  cnt_load;
  logic [STAGES-1:0]     hold;
  logic [STAGES-1:0]     vld_nxt;
  logic                  inject;
  logic                  older_stall;

  // busy and stg_en are both forced low while reset is asserted. The state
  // registers are not cleared until the reset edge, so they cannot be used
  // directly during that cycle.
  always_comb begin
    busy = reset & (wait_cnt != CNT_ZERO);
  end

  // Stage i is held by the global stall, by an active wait counter, or by a
  // stall request from stage i or from any older stage. Walking from the
  // oldest stage down accumulates that suffix-OR.
  always_comb begin
    hold        = '0;
    older_stall = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      older_stall = older_stall | stg_stall_req[i];
      hold[i]     = ~stallb_en | busy | older_stall;
    end
  end

  always_comb begin
    stg_en = reset ? ~hold : '0;
  end

  // The counter loads only from idle and only for a non-zero count.
  // A zero count therefore never produces a stall cycle, and a mem_start that
  // arrives while the counter is running is dropped.
  always_comb begin
    cnt_load = mem_start && (wait_cnt == CNT_ZERO) && (mem_wait != CNT_ZERO);
    if (cnt_load) begin
      cnt_nxt = mem_wait;
    end else if (wait_cnt != CNT_ZERO) begin
      cnt_nxt = wait_cnt - CNT_ONE;
    end else begin
      cnt_nxt = wait_cnt;
    end
  end

  // Fetch inserts real instructions only while the core is running normally.
  // During a drain it inserts bubbles, and the ACK cycle inserts one more.
  always_comb begin
    inject = (state == ST_RUN) || (state == ST_WAIT);
  end

  // Next valid vector.
  //   - An enabled stage takes its predecessor's valid if the predecessor also
  //     advances; otherwise it takes a bubble.
  //   - A held stage keeps its valid.
  //   - Flush then clears the youngest stages even when they are held.
  always_comb begin
    vld_nxt = stg_vld;
    if (stg_en[0]) begin
      vld_nxt[0] = inject;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (stg_en[i]) begin
        vld_nxt[i] = stg_en[i-1] & stg_vld[i-1];
      end
    end
    if (flush) begin
      for (int i = 0; i < FLUSH_DEPTH; i++) begin
        vld_nxt[i] = 1'b0;
      end
    end
  end

  // ---- registered stage: valids, wait counter, control FSM ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_RUN;
      wait_cnt <= CNT_ZERO;
      stg_vld  <= '0;
      irq_ack  <= 1'b0;
    end else begin
      stg_vld  <= vld_nxt;
      wait_cnt <= cnt_nxt;
      irq_ack  <= 1'b0;
      case (state)
        ST_RUN: begin
          // A memory access wins over an interrupt in the same cycle. The
          // interrupt stays pending and is taken after the wait completes.
          if (cnt_load) begin
            state <= ST_WAIT;
          end else if (interrupt) begin
            state <= ST_DRAIN;
          end
        end
        ST_WAIT: begin
          if (cnt_nxt == CNT_ZERO) begin
            state <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          // Check for empty after this edge's update, so that irq_ack and
          // the first all-empty valid vector appear together.
          if (vld_nxt == '0) begin
            state   <= ST_ACK;
            irq_ack <= 1'b1;
          end
        end
        ST_ACK: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
module tb_pipe_stage_ctrl;

  localparam int STAGES      = 4;
  localparam int WAIT_WIDTH  = 4;
  localparam int FLUSH_DEPTH = 2;

  logic                  clk;
  logic                  reset;
  logic                  stallb_en;
  logic [STAGES-1:0]     stg_stall_req;
  logic                  mem_start;
  logic [WAIT_WIDTH-1:0] mem_wait;
  logic                  flush;
  logic                  interrupt;
  logic                  irq_ack;
  logic [STAGES-1:0]     stg_en;
  logic [STAGES-1:0]     stg_vld;
  logic                  busy;

  pipe_stage_ctrl #(
    .STAGES     (STAGES),
    .WAIT_WIDTH (WAIT_WIDTH),
    .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stallb_en    (stallb_en),
    .stg_stall_req(stg_stall_req),
    .mem_start    (mem_start),
    .mem_wait     (mem_wait),
    .flush        (flush),
    .interrupt    (interrupt),
    .irq_ack      (irq_ack),
    .stg_en       (stg_en),
    .stg_vld      (stg_vld),
    .busy         (busy)
  );

  typedef struct {
    string       name;
    logic [3:0]  en;
    logic [3:0]  vld;
    logic        bsy;
    logic        ack;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   stim_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each cycle, drive the inputs just after the rising edge. The expected
  // outputs for that same cycle are queued and checked at the falling edge.
  task automatic cyc(input logic rst_n, input logic sb, input logic [3:0] req,
                     input logic ms, input logic [3:0] mw, input logic fl,
                     input logic irq, input string nm, input logic [3:0] e_en,
                     input logic [3:0] e_vld, input logic e_busy,
                     input logic e_ack);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst_n;
    stallb_en     = sb;
    stg_stall_req = req;
    mem_start     = ms;
    mem_wait      = mw;
    flush         = fl;
    interrupt     = irq;
    e.name = nm;
    e.en   = e_en;
    e.vld  = e_vld;
    e.bsy  = e_busy;
    e.ack  = e_ack;
    q.push_back(e);
  endtask

  // Monitor: compares whenever an expected entry is waiting.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (stg_en !== e.en || stg_vld !== e.vld || busy !== e.bsy ||
          irq_ack !== e.ack) begin
        n_fail++;
        $display("FAIL %s: got en=%b vld=%b busy=%b ack=%b, want en=%b vld=%b busy=%b ack=%b",
                 e.name, stg_en, stg_vld, busy, irq_ack,
                 e.en, e.vld, e.bsy, e.ack);
      end
    end
  end

  initial begin
    reset = 1'b0; stallb_en = 1'b1; stg_stall_req = '0; mem_start = 1'b0;
    mem_wait = '0; flush = 1'b0; interrupt = 1'b0;

    // rst sb req   ms mw     fl irq name            en       vld      bsy  ack
    cyc(0, 1, 4'b0000, 0, 4'd0, 0, 0, "reset_hold",  4'b0000, 4'b0000, 0, 0);
    // T1: fill from empty
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t1_c0",       4'b1111, 4'b0000, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t1_c1",       4'b1111, 4'b0001, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t1_c2",       4'b1111, 4'b0011, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t1_c3",       4'b1111, 4'b0111, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t1_full",     4'b1111, 4'b1111, 0, 0);
    // T2: stage 2 stall for two cycles
    cyc(1, 1, 4'b0100, 0, 4'd0, 0, 0, "t2_stall0",   4'b1000, 4'b1111, 0, 0);
    cyc(1, 1, 4'b0100, 0, 4'd0, 0, 0, "t2_stall1",   4'b1000, 4'b0111, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t2_rel",      4'b1111, 4'b0111, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t2_refill",   4'b1111, 4'b1111, 0, 0);
    // T3: three wait states, then a zero-wait access
    cyc(1, 1, 4'b0000, 1, 4'd3, 0, 0, "t3_start",    4'b1111, 4'b1111, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t3_wait3",    4'b0000, 4'b1111, 1, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t3_wait2",    4'b0000, 4'b1111, 1, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t3_wait1",    4'b0000, 4'b1111, 1, 0);
    cyc(1, 1, 4'b0000, 1, 4'd0, 0, 0, "t3_done_w0",  4'b1111, 4'b1111, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t3_w0_nostl", 4'b1111, 4'b1111, 0, 0);
    // T4: interrupt drain; the request drops during DRAIN without aborting it
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 1, "t4_irq",      4'b1111, 4'b1111, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t4_drain0",   4'b1111, 4'b1111, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t4_drain1",   4'b1111, 4'b1110, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t4_drain2",   4'b1111, 4'b1100, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t4_drain3",   4'b1111, 4'b1000, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t4_ack",      4'b1111, 4'b0000, 0, 1);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t4_post_ack", 4'b1111, 4'b0000, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t4_resume",   4'b1111, 4'b0001, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t4_fill2",    4'b1111, 4'b0011, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t4_fill3",    4'b1111, 4'b0111, 0, 0);
    // T5: flush together with the global stall
    cyc(1, 0, 4'b0000, 0, 4'd0, 1, 0, "t5_flush",    4'b0000, 4'b1111, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t5_after",    4'b1111, 4'b1100, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t5_shift",    4'b1111, 4'b1001, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t5_shift2",   4'b1111, 4'b0011, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t5_shift3",   4'b1111, 4'b0111, 0, 0);
    // mem_start while busy must be dropped
    cyc(1, 1, 4'b0000, 1, 4'd2, 0, 0, "ign_start",   4'b1111, 4'b1111, 0, 0);
    cyc(1, 1, 4'b0000, 1, 4'd5, 0, 0, "ign_busy2",   4'b0000, 4'b1111, 1, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "ign_busy1",   4'b0000, 4'b1111, 1, 0);
    // T6: reset while the counter holds 2 in WAIT
    cyc(1, 1, 4'b0000, 1, 4'd3, 0, 0, "t6_start",    4'b1111, 4'b1111, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t6_wait3",    4'b0000, 4'b1111, 1, 0);
    cyc(0, 1, 4'b0000, 0, 4'd0, 0, 0, "t6_rst",      4'b0000, 4'b1111, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "t6_after",    4'b1111, 4'b0000, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 1, "t6_run",      4'b1111, 4'b0001, 0, 0);
    // reset during a drain: no irq_ack, and the pipeline restarts in RUN
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "dr_drain",    4'b1111, 4'b0011, 0, 0);
    cyc(0, 1, 4'b0000, 0, 4'd0, 0, 0, "dr_rst",      4'b0000, 4'b0110, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "dr_after",    4'b1111, 4'b0000, 0, 0);
    cyc(1, 1, 4'b0000, 0, 4'd0, 0, 0, "dr_no_ack",   4'b1111, 4'b0001, 0, 0);
    // oldest-stage stall holds everything
    cyc(1, 1, 4'b1000, 0, 4'd0, 0, 0, "old_stall",   4'b0000, 4'b0011, 0, 0);

    @(negedge clk);
    @(posedge clk);
    stim_done = 1;
  end

  initial begin
    fork
      wait (stim_done);
      #100000;
    join_any
    if (!stim_done) begin
      n_fail++;
      $display("FAIL watchdog: stimulus incomplete, want completion before time limit");
    end
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
